// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops plus a WIDTH-cycle shift-add multiply.
// Operands enter and results leave through valid/ready handshakes.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       alu_control_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             bad_op,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     w_accept;
    logic                     w_is_mul;
    logic [WIDTH-1:0]         r_mcand;
    logic [WIDTH-1:0]         r_mplier;
    logic [WIDTH-1:0]         r_acc;
    logic [CNT_W-1:0]         r_cnt;
    logic [WIDTH-1:0]         w_acc_nxt;
    logic                     w_mul_last;
    logic [WIDTH-1:0]         r_result;
    logic                     r_zero;
    logic                     r_ovf;
    logic                     r_bad;
    logic [WIDTH-1:0]         w_sum;
    logic [WIDTH-1:0]         w_diff;
    logic signed [WIDTH-1:0]  w_a_s;
    logic signed [WIDTH-1:0]  w_b_s;
    logic [WIDTH-1:0]         w_alu_res;
    logic                     w_alu_ovf;
    logic                     w_alu_bad;

    assign result     = r_result;
    assign zero       = r_zero;
    assign overflow   = r_ovf;
    assign bad_op     = r_bad;
    assign w_is_mul   = (alu_control_in == OP_MUL);
    assign w_accept   = in_valid && in_ready;
    assign w_mul_last = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = w_is_mul ? S_MUL : S_HOLD;
            S_MUL:  if (w_mul_last) w_state_nxt = S_HOLD;
            S_HOLD: begin
                if (w_accept)       w_state_nxt = w_is_mul ? S_MUL : S_HOLD;
                else if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A held result may be retired and replaced in the same cycle, so HOLD accepts when the consumer takes it.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: in_ready = !reset;
            S_HOLD: begin
                in_ready  = out_ready && !reset;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_sum     = a + b;
        w_diff    = a - b;
        w_a_s     = a;
        w_b_s     = b;
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        w_alu_bad = 1'b0;
        case (alu_control_in)
            OP_ADD: begin
                w_alu_res = w_sum;
                w_alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res = w_diff;
                w_alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: w_alu_res = a & b;
            OP_OR:  w_alu_res = a | b;
            OP_NOR: w_alu_res = ~(a | b);
            OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, (w_a_s < w_b_s)};
            OP_MUL: w_alu_res = '0;
            default: w_alu_bad = 1'b1;
        endcase
    end

    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_bad    <= 1'b0;
        end else if (w_accept) begin
            if (w_is_mul) begin
                r_mcand  <= a;
                r_mplier <= b;
                r_acc    <= '0;
                r_cnt    <= CNT_W'(WIDTH);
            end else begin
                r_result <= w_alu_res;
                r_zero   <= (w_alu_res == '0);
                r_ovf    <= w_alu_ovf;
                r_bad    <= w_alu_bad;
            end
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CNT_W'(1);
            if (w_mul_last) begin
                r_result <= w_acc_nxt;
                r_zero   <= (w_acc_nxt == '0);
                r_ovf    <= 1'b0;
                r_bad    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results are queued at issue and popped when out_valid appears.
module tb_alu_exec_unit;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_MUL = 4'b1000;
    localparam logic [3:0] C_NOR = 4'b1100;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic        bad;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [3:0]  alu_control_in;
    logic [31:0] a;
    logic [31:0] b;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        bad_op;
    logic        out_valid;
    logic        out_ready;

    exp_t sb[$];
    exp_t exp_v;
    int   checks;
    int   errors;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .alu_control_in(alu_control_in), .a(a), .b(b),
        .in_valid(in_valid), .in_ready(in_ready), .result(result), .zero(zero),
        .overflow(overflow), .bad_op(bad_op), .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      sx;
        longint      sy;
        longint      s;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e  = '0;
        case (c)
            C_ADD: begin s = sx + sy; e.res = x + y; e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            C_SUB: begin s = sx - sy; e.res = x - y; e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            C_AND: e.res = x & y;
            C_OR:  e.res = x | y;
            C_NOR: e.res = ~(x | y);
            C_SLT: e.res = (sx < sy) ? 32'd1 : 32'd0;
            C_MUL: begin p = {32'd0, x} * {32'd0, y}; e.res = p[31:0]; end
            default: begin e.res = 32'd0; e.bad = 1'b1; end
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        alu_control_in = c;
        a              = x;
        b              = y;
        in_valid       = 1'b1;
        sb.push_back(model(c, x, y));
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_control_in = 4'd0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({result, zero, overflow, bad_op, out_valid, in_ready} !== 37'd0) begin
            errors++;
            $display("FAIL reset_state: got r=%h z=%b o=%b b=%b v=%b rdy=%b want all 0",
                     result, zero, overflow, bad_op, out_valid, in_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_single_cycle_ops();
        logic [3:0]  tc [13] = '{C_ADD, C_SUB, C_ADD, C_SUB, C_SUB, C_AND, C_OR,
                                 C_SLT, C_SLT, C_NOR, 4'b1111, 4'b0011, C_ADD};
        logic [31:0] ta [13] = '{32'd5, 32'd9, 32'h7FFF_FFFF, 32'h8000_0000, 32'd5, 32'hF0F0_FF00,
                                 32'hF0F0_0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd3, 32'd8, 32'hFFFF_FFFF};
        logic [31:0] tb [13] = '{32'd7, 32'd9, 32'd1, 32'd1, 32'd7, 32'h0FF0_F0F0,
                                 32'h0000_0F0F, 32'd1, 32'hFFFF_FFFF, 32'h0000_00FF, 32'd4, 32'd8, 32'd1};
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL op%0d_ready: got %b want 1", i, in_ready);
            end
            drive(tc[i], ta[i], tb[i]);
            step();
            in_valid = 1'b0;
            exp_v = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || {result, zero, overflow, bad_op} !== exp_v) begin
                errors++;
                $display("FAIL op%0d: got v=%b r=%h z=%b o=%b b=%b want v=1 r=%h z=%b o=%b b=%b",
                         i, out_valid, result, zero, overflow, bad_op, exp_v.res, exp_v.z, exp_v.ov, exp_v.bad);
            end
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL op%0d_retire: got out_valid=%b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_mul();
        logic bad_phase;
        out_ready = 1'b1;
        drive(C_MUL, 32'hFFFF_FFFF, 32'd3);
        step();
        bad_phase = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                bad_phase = 1'b1;
                $display("FAIL mul_busy_cycle%0d: got rdy=%b v=%b want 0 0", i, in_ready, out_valid);
            end
            in_valid       = i[0];
            alu_control_in = C_ADD;
            a              = 32'(i);
            b              = 32'(i);
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (bad_phase) errors++;
        exp_v = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || {result, zero, overflow, bad_op} !== exp_v) begin
            errors++;
            $display("FAIL mul_result: got v=%b r=%h z=%b o=%b b=%b want v=1 r=%h z=%b o=%b b=%b",
                     out_valid, result, zero, overflow, bad_op, exp_v.res, exp_v.z, exp_v.ov, exp_v.bad);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL mul_retire: got out_valid=%b pending=%0d want 0 0", out_valid, sb.size());
        end
    endtask

    task automatic test_backpressure();
        logic bad_hold;
        out_ready = 1'b0;
        drive(C_ADD, 32'd1, 32'd1);
        step();
        in_valid = 1'b0;
        bad_hold = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {result, zero, overflow, bad_op} !== sb[0]) begin
                bad_hold = 1'b1;
                $display("FAIL hold_cycle%0d: got v=%b rdy=%b r=%h want v=1 rdy=0 r=%h",
                         i, out_valid, in_ready, result, sb[0].res);
            end
            step();
        end
        checks++;
        if (bad_hold) errors++;
        out_ready = 1'b1;
        exp_v = sb.pop_front();
        drive(C_SUB, 32'd4, 32'd1);
        #1;
        checks++;
        if (in_ready !== 1'b1 || {result, zero, overflow, bad_op} !== exp_v) begin
            errors++;
            $display("FAIL hold_release: got rdy=%b r=%h want rdy=1 r=%h", in_ready, result, exp_v.res);
        end
        step();
        in_valid = 1'b0;
        exp_v = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || {result, zero, overflow, bad_op} !== exp_v) begin
            errors++;
            $display("FAIL hold_next_op: got v=%b r=%h want v=1 r=%h", out_valid, result, exp_v.res);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  tc [4] = '{C_ADD, C_SUB, C_OR, 4'b1010};
        logic [31:0] ta [4] = '{32'd10, 32'd3, 32'h1234_0000, 32'd1};
        logic [31:0] tb [4] = '{32'd20, 32'd5, 32'h0000_5678, 32'd2};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(tc[i], ta[i], tb[i]);
            step();
            exp_v = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || {result, zero, overflow, bad_op} !== exp_v) begin
                errors++;
                $display("FAIL b2b%0d: got v=%b r=%h z=%b o=%b b=%b want v=1 r=%h z=%b o=%b b=%b",
                         i, out_valid, result, zero, overflow, bad_op, exp_v.res, exp_v.z, exp_v.ov, exp_v.bad);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        logic seen_valid;
        int   n;
        out_ready = 1'b1;
        drive(C_MUL, 32'd6, 32'd7);
        step();
        in_valid = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        #1;
        sb.delete();
        checks++;
        if ({result, zero, overflow, bad_op, out_valid, in_ready} !== 37'd0) begin
            errors++;
            $display("FAIL reset_mid_mul: got r=%h z=%b o=%b b=%b v=%b rdy=%b want all 0",
                     result, zero, overflow, bad_op, out_valid, in_ready);
        end
        repeat (2) step();
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready: got %b want 1", in_ready);
        end
        seen_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid !== 1'b0) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid) begin
            errors++;
            $display("FAIL reset_mid_ghost: got out_valid=1 after abort want 0");
        end
        drive(C_MUL, 32'd6, 32'd7);
        step();
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        exp_v = sb.pop_front();
        checks++;
        if (n != 32 || out_valid !== 1'b1 || {result, zero, overflow, bad_op} !== exp_v) begin
            errors++;
            $display("FAIL mul_after_reset: got v=%b r=%h wait=%0d want v=1 r=%h wait=32",
                     out_valid, result, n, exp_v.res);
        end
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_cycle_ops();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Multi-cycle ALU execution unit that consumes the 4-bit ALU control code produced by the ALU control decoder, together with two operands. It sits at the receiving end of the decoder's control interface in the execute stage. Logical and arithmetic ops complete in one cycle. A shift-add multiply takes WIDTH cycles. Operands enter and results leave through valid/ready handshakes, so the unit can stall the datapath.

Parameters:
WIDTH, 32, operand/result width in bits (must be >= 2)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
alu_control_in  input  4  op code: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt, 1100 nor, 1000 mul (low WIDTH bits)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
in_valid  input  1  operands and op valid
in_ready  output  1  unit can accept an op this cycle
result  output  WIDTH  registered result
zero  output  1  registered (result == 0)
overflow  output  1  registered signed overflow (add/sub only, else 0)
bad_op  output  1  registered flag, code not in the list above
out_valid  output  1  result/flags valid
out_ready  input  1  consumer takes result this cycle

Behaviour:
- Reset is asynchronous: the state is IDLE, and result, zero, overflow, bad_op and out_valid are 0, the multiply counter and accumulators are 0, and in_ready is 0 while reset is high.
- States are IDLE, MUL and HOLD.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). It is combinational and is 0 in MUL.
- An op is accepted on a clock edge with in_valid && in_ready. The op, a and b are captured at that edge and must not be sampled again.
- Single-cycle ops go to HOLD at the accept edge, with result/flags registered. out_valid is high in the very next cycle, so latency is 1.
  - add: result = a+b mod 2^WIDTH. overflow = operand signs equal and result sign differs.
  - sub: result = a-b mod 2^WIDTH. overflow = operand signs differ and result sign differs from a.
  - and, or, nor: bitwise. slt: result = 1 if signed a < signed b, else 0.
  - An unknown code gives result 0, zero=1 and bad_op=1, with latency 1.
- mul moves IDLE/HOLD to MUL at the accept edge. The counter loads WIDTH.
  - Each edge in MUL: if the multiplier LSB is 1, the accumulator += multiplicand. Then the multiplicand shifts left 1, the multiplier shifts right 1, and the counter decrements.
  - At the edge where the counter goes 1->0, the low WIDTH bits of the accumulator go to result and the state goes to HOLD. out_valid is high after exactly WIDTH+1 edges from accept (33 for WIDTH=32).
  - overflow=0 and bad_op=0 for mul. The result is the unsigned-product low bits, which equal the two's-complement low bits.
- HOLD: out_valid=1. result and flags stay stable while out_ready=0.
  - out_ready=1 and no new accept: go to IDLE, out_valid=0 next cycle.
  - out_ready=1 with a simultaneous accept: the old result is retired and the new op is processed per the rules above, with no bubble for single-cycle ops.
- zero is always computed from the value written into result.
- in_valid and operand changes during MUL are ignored.
- Reset asserted mid-MUL or mid-HOLD aborts the op immediately. No out_valid is produced for it.

Test Plan:
- Add: code 0010, a=5, b=7, out_ready=1 -> next cycle out_valid=1, result=12, zero=0, overflow=0. Then out_valid=0 the cycle after.
- Sub and overflow: code 0110, a=b=0x0000_0009 -> result=0, zero=1. Then code 0010, a=0x7FFF_FFFF, b=1 -> result=0x8000_0000, overflow=1.
- slt and nor: code 0111, a=0xFFFF_FFFF, b=1 -> result=1. Code 1100, a=0, b=0x0000_00FF -> result=0xFFFF_FF00. Code 1111 -> result=0, bad_op=1.
- Multiply: code 1000, a=0xFFFF_FFFF, b=3 -> in_ready=0 for 32 cycles. out_valid rises after 33 edges with result=0xFFFF_FFFD. in_valid pulses during MUL are ignored.
- Backpressure/back-to-back: hold out_ready=0 for 5 cycles after add 1+1 -> result stays 2 and in_ready=0. Then assert out_ready with in_valid (sub 4-1) in the same cycle -> next cycle result=3, out_valid=1.
- Reset mid-op: start mul 6*7 and assert reset at cycle 10 -> outputs 0 immediately. After release, in_ready=1 and no out_valid appears. A fresh mul 6*7 then yields 42.
